// File: rtl/rx_fifo_buff.sv
// rx_fifo_buff: DEPTH-entry first-word-fall-through receive buffer.
// The head entry is always visible on rx_data; while empty the idle-line
// value is shown instead. Writes to a full buffer are dropped and flagged
// through the sticky overrun_error.
// Optional build macro RX_FIFO_UNDERRUN_EN adds a sticky underrun_error
// output that flags reads attempted while the buffer is empty.
module rx_fifo_buff #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_VALUE = {DATA_WIDTH{1'b1}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_buffer,
  input  logic [DATA_WIDTH-1:0]        packet_data,
  input  logic                         data_read,
  output logic [DATA_WIDTH-1:0]        rx_data,
  output logic                         data_ready,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   fill_count,
  output logic                         overrun_error
`ifdef RX_FIFO_UNDERRUN_EN
  ,
  output logic                         underrun_error
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  wr_en, rd_en;

  // A DEPTH below 2 cannot provide real buffering; refuse to elaborate.
  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("rx_fifo_buff: DEPTH must be >= 2");
    end
  endgenerate

  // Accept/pop decisions and next-state for pointers, count and overrun flag.
  always_comb begin
    rd_en     = data_read && (count_q != '0);
    // A full buffer still accepts a write when the head is popped this cycle.
    wr_en     = load_buffer && ((count_q != FULL_CNT) || rd_en);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end
    if (wr_en && !rd_en) begin
      count_d = count_q + CW'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CW'(1);
    end
    // A dropped write sets the flag; that outranks the clear from data_read.
    if (load_buffer && !wr_en) begin
      overrun_d = 1'b1;
    end else if (data_read) begin
      overrun_d = 1'b0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage array; contents need no reset since count_q gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= packet_data;
    end
  end

  // Head of queue from registered state only, idle value while empty.
  always_comb begin
    rx_data = IDLE_VALUE;
    if (count_q != '0) begin
      rx_data = mem_q[rd_ptr_q];
    end
  end

  assign data_ready    = (count_q != '0);
  assign full          = (count_q == FULL_CNT);
  assign fill_count    = count_q;
  assign overrun_error = overrun_q;

`ifdef RX_FIFO_UNDERRUN_EN
  logic underrun_q, underrun_d;

  // Read on empty with no write sets the flag; the next accepted write clears it.
  always_comb begin
    underrun_d = underrun_q;
    if (data_read && (count_q == '0) && !load_buffer) begin
      underrun_d = 1'b1;
    end else if (wr_en) begin
      underrun_d = 1'b0;
    end
  end

  // Underrun flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign underrun_error = underrun_q;
`endif

`ifndef SYNTHESIS
  // Flag undriven or unknown control/data inputs at each sampling edge.
  always @(posedge clk) begin
    if ($isunknown({load_buffer, data_read, packet_data, rst})) begin
      $error("rx_fifo_buff: X/Z detected on an input");
    end
  end
`endif

endmodule
